exe_wb_arbiter: RTL and testbench

Writeback-bus arbiter between the execution units and the reorder buffer / register file. Up to REQ execution units raise completed results (ROB tag + data) with valid/ready handshakes. Each cycle the arbiter grants one of them and registers the winner onto a single writeback bus, which drives the downstream consumer's valid/ready handshake. It sits between exe_top and the ROB/writeback logic and owns the only path results take out of the execution stage.

---
 rtl/cpu_exe_pkg.sv | 21 ++
 rtl/wb_rr_pick.sv | 40 ++++
 rtl/exe_wb_arbiter.sv | 77 +++++++
 tb/tb_exe_wb_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_exe_pkg.sv
// rtl/cpu_exe_pkg.sv - shared execution-stage types and default sizes
// Holds writeback request layout and source index type used by exe_wb_arbiter.
`ifndef DataWidth
`define DataWidth 32
`endif

package cpu_exe_pkg;

   localparam int REQ_DEFAULT  = 4;
   localparam int TAG_DEFAULT  = 5;
   localparam int DATA_DEFAULT = `DataWidth;
   localparam int SRC_DEFAULT  = $clog2(REQ_DEFAULT);

   typedef logic [SRC_DEFAULT-1:0] SrcIdx_t;

   typedef struct packed {
      logic [TAG_DEFAULT-1:0]  tag;
      logic [DATA_DEFAULT-1:0] data;
   } WbReq_t;

endpackage

// File: rtl/wb_rr_pick.sv
// rtl/wb_rr_pick.sv - combinational pointer-based request picker
// Searches from ptr upward, wrapping modulo REQ; ptr tied to 0 gives fixed priority.
module wb_rr_pick #(
   parameter int REQ = 4,
   parameter int SRC = $clog2(REQ)
) (
   input  logic [REQ-1:0] req,
   input  logic [SRC-1:0] ptr,
   output logic [REQ-1:0] grant,
   output logic [SRC-1:0] idx,
   output logic           any
);

   localparam int SW = SRC + 1;

   logic [SW-1:0]  sum;
   logic [SRC-1:0] k;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      sum   = '0;
      k     = '0;
      for (int i = 0; i < REQ; i++) begin
         // one extra bit so ptr+i can exceed REQ-1 before the wrap
         sum = {1'b0, ptr} + SW'(i);
         if (sum >= SW'(REQ)) begin
            sum = sum - SW'(REQ);
         end
         k = sum[SRC-1:0];
         if (!any && req[k]) begin
            any      = 1'b1;
            grant[k] = 1'b1;
            idx      = k;
         end
      end
   end

endmodule

// File: rtl/exe_wb_arbiter.sv
// rtl/exe_wb_arbiter.sv - execution-unit to writeback bus arbiter with one output register
// WB_ARB_RR_EN selects round-robin priority; undefined gives fixed lowest-index priority.
module exe_wb_arbiter
   import cpu_exe_pkg::*;
#(
   parameter int REQ  = REQ_DEFAULT,
   parameter int DATA = DATA_DEFAULT,
   parameter int TAG  = TAG_DEFAULT,
   parameter int SRC  = $clog2(REQ)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic [REQ-1:0]           req_valid,
   input  logic [REQ-1:0][TAG-1:0]  req_tag,
   input  logic [REQ-1:0][DATA-1:0] req_data,
   output logic [REQ-1:0]           req_ready,
   output logic                     wb_valid,
   output logic [TAG-1:0]           wb_tag,
   output logic [DATA-1:0]          wb_data,
   output logic [SRC-1:0]           wb_src,
   input  logic                     wb_ready
);

   logic           load;
   logic [SRC-1:0] ptr;
   logic [REQ-1:0] pick_grant;
   logic [SRC-1:0] pick_idx;
   logic           pick_any;

   // the output slot is free when empty or being drained this cycle
   assign load = !flush && (!wb_valid || wb_ready);

   wb_rr_pick #(
      .REQ (REQ),
      .SRC (SRC)
   ) u_pick (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

`ifdef WB_ARB_RR_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr <= '0;
      end else if (load && pick_any) begin
         ptr <= (pick_idx == SRC'(REQ - 1)) ? '0 : pick_idx + SRC'(1);
      end
   end
`else
   assign ptr = '0;
`endif

   assign req_ready = load ? pick_grant : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_valid <= 1'b0;
         wb_tag   <= '0;
         wb_data  <= '0;
         wb_src   <= '0;
      end else if (flush) begin
         wb_valid <= 1'b0;
      end else if (load) begin
         wb_valid <= pick_any;
         if (pick_any) begin
            wb_tag  <= req_tag[pick_idx];
            wb_data <= req_data[pick_idx];
            wb_src  <= pick_idx;
         end
      end
   end

endmodule

// File: tb/tb_exe_wb_arbiter.sv
// tb/tb_exe_wb_arbiter.sv - self-checking bench for exe_wb_arbiter (both WB_ARB_RR_EN modes)
module tb_exe_wb_arbiter;

   localparam int REQ  = 4;
   localparam int TAG  = 5;
   localparam int DATA = 32;
`ifdef WB_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic                     clk = 1'b0;
   logic                     reset;
   logic                     flush;
   logic [REQ-1:0]           req_valid;
   logic [REQ-1:0][TAG-1:0]  req_tag;
   logic [REQ-1:0][DATA-1:0] req_data;
   logic [REQ-1:0]           req_ready;
   logic                     wb_valid;
   logic [TAG-1:0]           wb_tag;
   logic [DATA-1:0]          wb_data;
   logic [1:0]               wb_src;
   logic                     wb_ready;

   int checks = 0;
   int failures = 0;

   exe_wb_arbiter #(.REQ(REQ), .DATA(DATA), .TAG(TAG)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .req_valid (req_valid),
      .req_tag   (req_tag),
      .req_data  (req_data),
      .req_ready (req_ready),
      .wb_valid  (wb_valid),
      .wb_tag    (wb_tag),
      .wb_data   (wb_data),
      .wb_src    (wb_src),
      .wb_ready  (wb_ready)
   );

   always #5 clk = ~clk;

   // reference model: one result slot plus a rotating start index
   logic            m_valid;
   logic [TAG-1:0]  m_tag;
   logic [DATA-1:0] m_data;
   int              m_src;
   int              m_ptr;
   int              m_win;
   logic            m_load;
   logic [REQ-1:0]  m_ready;

   function automatic int winner(input logic [REQ-1:0] v, input int p);
      for (int i = 0; i < REQ; i++) begin
         if (v[(p + i) % REQ]) return (p + i) % REQ;
      end
      return -1;
   endfunction

   always_comb begin
      m_win   = winner(req_valid, m_ptr);
      m_load  = !flush && (!m_valid || wb_ready);
      m_ready = '0;
      if (m_load && m_win >= 0) m_ready = REQ'(1) << m_win;
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_valid <= 1'b0;
         m_tag   <= '0;
         m_data  <= '0;
         m_src   <= 0;
         m_ptr   <= 0;
      end else if (flush) begin
         m_valid <= 1'b0;
      end else if (m_load) begin
         m_valid <= (m_win >= 0);
         if (m_win >= 0) begin
            m_tag  <= req_tag[m_win[1:0]];
            m_data <= req_data[m_win[1:0]];
            m_src  <= m_win;
            if (RR) m_ptr <= (m_win + 1) % REQ;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic settle();
      #1;
      check("model_req_ready", 64'(req_ready), 64'(m_ready));
      check("model_wb_valid", 64'(wb_valid), 64'(m_valid));
      if (m_valid) begin
         check("model_wb_tag", 64'(wb_tag), 64'(m_tag));
         check("model_wb_data", 64'(wb_data), 64'(m_data));
         check("model_wb_src", 64'(wb_src), 64'(m_src));
      end
   endtask

   task automatic next_edge();
      @(negedge clk);
   endtask

   task automatic set_payloads();
      for (int i = 0; i < REQ; i++) begin
         req_tag[i]  = TAG'(8 + i);
         req_data[i] = 32'hA000_0000 + DATA'(i);
      end
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #1;
      next_edge();
      reset = 1'b0;
   endtask

   int seq [5];
   int e_first;
   logic [REQ-1:0] e_ready;

   initial begin
      reset = 1'b1; flush = 1'b0; req_valid = '0; wb_ready = 1'b0;
      set_payloads();
      for (int k = 0; k < 5; k++) seq[k] = RR ? (k % REQ) : 0;
      repeat (2) @(posedge clk);
      next_edge();
      reset = 1'b0;
      settle();
      check("reset_req_ready", 64'(req_ready), 64'h0);
      check("reset_wb_valid", 64'(wb_valid), 64'h0);
      check("reset_wb_tag", 64'(wb_tag), 64'h0);
      check("reset_wb_data", 64'(wb_data), 64'h0);
      check("reset_wb_src", 64'(wb_src), 64'h0);

      // single request from unit 2
      req_valid = 4'b0100; req_tag[2] = 5'd5; req_data[2] = 32'hDEAD_BEEF; wb_ready = 1'b1;
      settle();
      check("single_req_ready", 64'(req_ready), 64'h4);
      next_edge();
      req_valid = '0;
      settle();
      check("single_wb_valid", 64'(wb_valid), 64'h1);
      check("single_wb_tag", 64'(wb_tag), 64'h5);
      check("single_wb_data", 64'(wb_data), 64'hDEAD_BEEF);
      check("single_wb_src", 64'(wb_src), 64'h2);
      next_edge();
      settle();
      check("drain_wb_valid", 64'(wb_valid), 64'h0);

      // backpressure
      set_payloads();
      req_valid = 4'b1111; wb_ready = 1'b0;
      e_first = RR ? 3 : 0;
      settle();
      next_edge();
      for (int c = 0; c < 3; c++) begin
         settle();
         check("bp_req_ready", 64'(req_ready), 64'h0);
         check("bp_wb_src", 64'(wb_src), 64'(e_first));
         check("bp_wb_tag", 64'(wb_tag), 64'(8 + e_first));
         next_edge();
      end
      wb_ready = 1'b1;
      settle();
      check("bp_release_ready", 64'(req_ready), 64'h1);
      next_edge();
      settle();
      check("bp_no_bubble_valid", 64'(wb_valid), 64'h1);
      check("bp_no_bubble_src", 64'(wb_src), 64'h0);

      // priority sequence with all units requesting
      pulse_reset();
      req_valid = 4'b1111; wb_ready = 1'b1;
      settle();
      for (int k = 0; k < 5; k++) begin
         next_edge();
         settle();
         check("seq_wb_src", 64'(wb_src), 64'(seq[k]));
      end

      // pointer at 3 with sparse requests
      pulse_reset();
      req_valid = 4'b0100; wb_ready = 1'b1;
      settle();
      next_edge();
      req_valid = 4'b0011;
      settle();
      check("wrap_ready0", 64'(req_ready), 64'h1);
      next_edge();
      req_valid = 4'b0010;
      settle();
      check("wrap_src0", 64'(wb_src), 64'h0);
      check("wrap_ready1", 64'(req_ready), 64'h2);
      next_edge();
      req_valid = '0;
      settle();
      check("wrap_src1", 64'(wb_src), 64'h1);

      // flush while holding a result
      flush = 1'b1; wb_ready = 1'b0; req_valid = 4'b1111;
      settle();
      check("flush_req_ready", 64'(req_ready), 64'h0);
      check("flush_wb_valid_before", 64'(wb_valid), 64'h1);
      next_edge();
      flush = 1'b0;
      e_ready = RR ? 4'b0100 : 4'b0001;
      settle();
      check("flush_wb_valid_after", 64'(wb_valid), 64'h0);
      check("flush_ptr_kept", 64'(req_ready), 64'(e_ready));
      next_edge();
      settle();
      check("flush_reload_valid", 64'(wb_valid), 64'h1);

      // asynchronous reset between edges
      req_valid = 4'b1110; wb_ready = 1'b0;
      settle();
      reset = 1'b1;
      settle();
      check("async_wb_valid", 64'(wb_valid), 64'h0);
      next_edge();
      reset = 1'b0;
      settle();
      check("post_reset_ready", 64'(req_ready), 64'h2);
      next_edge();
      settle();
      check("post_reset_src", 64'(wb_src), 64'h1);
      check("post_reset_valid", 64'(wb_valid), 64'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
